// File: rtl/mplier_pkg.sv
// Shared constants and helpers for the pipelined multiplier.
package mplier_pkg;

  // Register stages between an accepted operand pair and its product.
  localparam int unsigned MPLIER_LAT = 3;

  // Width of the exact product of two width-bit operands.
  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

  // Baugh-Wooley constant for two's-complement operands: 2^width + 2^(2*width-1).
  // Returned in 64 bits; callers truncate to their product width.
  function automatic logic [63:0] bw_correction(input int unsigned width);
    logic [63:0] c;
    c = '0;
    c[width] = 1'b1;
    c[2*width-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mplier_pipe_csa_tree.sv
// Combinational carry-save reduction of WIDTH partial-product rows down to two rows.
// Rows are taken three at a time through full-adder rows each level (Wallace order);
// leftover rows pass straight to the next level.
module csa_tree
  import mplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0][2*WIDTH-1:0] pp_i,
  output logic [2*WIDTH-1:0]            sum_o,
  output logic [2*WIDTH-1:0]            carry_o
);

  localparam int unsigned PW = prod_width(WIDTH);

  // Number of rows still present after lvl reduction levels.
  function automatic int unsigned rows_at(input int unsigned lvl);
    int unsigned n;
    n = WIDTH;
    for (int unsigned k = 0; k < lvl; k++) begin
      if (n > 2) n = (n / 3) * 2 + n % 3;
    end
    return n;
  endfunction

  function automatic int unsigned num_levels();
    int unsigned n;
    int unsigned l;
    n = WIDTH;
    l = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (n > 2) begin
        n = (n / 3) * 2 + n % 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int unsigned Levels = num_levels();

  logic [PW-1:0] rows [Levels+1][WIDTH];

  for (genvar r = 0; r < WIDTH; r++) begin : g_in
    assign rows[0][r] = pp_i[r];
  end

  for (genvar l = 0; l < Levels; l++) begin : g_level
    localparam int unsigned NIn  = rows_at(l);
    localparam int unsigned NGrp = NIn / 3;
    localparam int unsigned NOut = rows_at(l + 1);

    for (genvar g = 0; g < NGrp; g++) begin : g_fa
      logic [PW-1:0] a, b, c, maj;
      assign a   = rows[l][3*g];
      assign b   = rows[l][3*g+1];
      assign c   = rows[l][3*g+2];
      assign maj = (a & b) | (a & c) | (b & c);
      assign rows[l+1][2*g]   = a ^ b ^ c;
      // Carry out of the top column falls off: the product is modulo 2^PW.
      assign rows[l+1][2*g+1] = {maj[PW-2:0], 1'b0};
    end

    for (genvar r = 3 * NGrp; r < NIn; r++) begin : g_pass
      assign rows[l+1][r-NGrp] = rows[l][r];
    end

    for (genvar r = NOut; r < WIDTH; r++) begin : g_zero
      assign rows[l+1][r] = '0;
    end
  end

  assign sum_o   = rows[Levels][0];
  assign carry_o = rows[Levels][1];

endmodule

// File: rtl/mplier_pipe.sv
// Three-stage pipelined WIDTH x WIDTH multiplier, unsigned or two's-complement per
// transaction, with valid/ready on both sides and a single global advance.
module mplier_pipe
  import mplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      mcand,
  input  logic [WIDTH-1:0]      mplier,
  input  logic                  tc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    product
);

  localparam int unsigned PW = prod_width(WIDTH);
  localparam logic [PW-1:0] BwCorr = PW'(bw_correction(WIDTH));
  // Low correction bit rides in partial-product row 0 (its bit WIDTH is otherwise empty);
  // the top bit is applied after the final add as a flip of the MSB.
  localparam logic [PW-1:0] BwMsb  = {1'b1, {(PW-1){1'b0}}} & BwCorr;
  localparam logic [PW-1:0] BwRow  = BwCorr & ~BwMsb;

  logic adv;

  logic             s1_valid, s1_tc;
  logic [WIDTH-1:0] s1_mcand, s1_mplier;
  logic             s2_valid, s2_tc;
  logic [PW-1:0]    s2_sum, s2_carry;

  logic [WIDTH-1:0][PW-1:0] pp;
  logic [PW-1:0]            tree_sum, tree_carry;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: capture operands and mode on acceptance; bubbles enter as valid = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_tc     <= 1'b0;
      s1_mcand  <= '0;
      s1_mplier <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_tc     <= tc;
        s1_mcand  <= mcand;
        s1_mplier <= mplier;
      end
    end
  end

  // Partial products; in signed mode the bits pairing exactly one operand MSB are inverted.
  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      for (int j = 0; j < int'(WIDTH); j++) begin
        pp[i][i+j] = (s1_mcand[j] & s1_mplier[i])
                   ^ (s1_tc & ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1)));
      end
    end
    if (s1_tc) pp[0] = pp[0] | BwRow;
  end

  csa_tree #(
    .WIDTH (WIDTH)
  ) u_csa_tree (
    .pp_i    (pp),
    .sum_o   (tree_sum),
    .carry_o (tree_carry)
  );

  // S2: register the two carry-save rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_tc    <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tc    <= s1_tc;
        s2_sum   <= tree_sum;
        s2_carry <= tree_carry;
      end
    end
  end

  // S3: final carry-propagate add; tc is consumed here, so the output stage keeps no copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        product <= (s2_sum + s2_carry) ^ (s2_tc ? BwMsb : '0);
      end
    end
  end

endmodule

// File: tb/tb_mplier_pipe.sv
// Bench for mplier_pipe: directed corner cases on an 8-bit instance, then concurrent
// randomised traffic on 8-, 16- and 5-bit instances against a plain-arithmetic model.
module tb_mplier_pipe;
  import mplier_pkg::*;

  localparam int N_STRESS = 10000;
  localparam int MAX_CYC  = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv [3];
  logic        ordy [3];
  logic        tcs [3];
  logic [31:0] mc [3];
  logic [31:0] mp [3];
  logic        ir [3];
  logic        ov [3];
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic [9:0]  prod5;
  logic [63:0] pr [3];
  int          wid [3];

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] exp_mem [3][N_STRESS];

  always_comb begin
    pr[0] = 64'(prod8);
    pr[1] = 64'(prod16);
    pr[2] = 64'(prod5);
  end

  mplier_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .mcand(mc[0][7:0]),
    .mplier(mp[0][7:0]), .tc(tcs[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .product(prod8)
  );
  mplier_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .mcand(mc[1][15:0]),
    .mplier(mp[1][15:0]), .tc(tcs[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .product(prod16)
  );
  mplier_pipe #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .mcand(mc[2][4:0]),
    .mplier(mp[2][4:0]), .tc(tcs[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .product(prod5)
  );

  // Exact product from integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic t);
    longint sa, sb;
    logic [63:0] m;
    sa = longint'(a);
    sb = longint'(b);
    if (t && a[w-1]) sa = sa - (longint'(1) << w);
    if (t && b[w-1]) sb = sb - (longint'(1) << w);
    m = (64'd1 << (2 * w)) - 64'd1;
    return 64'(sa * sb) & m;
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; tcs[i] = 1'b0; mc[i] = '0; mp[i] = '0;
    end
  endtask

  task automatic drain();
    idle_all();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, ov[i]);
      end
      n_cmp++;
      if (pr[i] !== 64'd0) begin
        n_fail++; $display("FAIL reset_product[%0d]: got %h want 0", i, pr[i]);
      end
      n_cmp++;
      if (ir[i] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, ir[i]);
      end
    end
  endtask

  task automatic test_unsigned_max();
    drain();
    iv[0] = 1'b1; mc[0] = 32'd255; mp[0] = 32'd255; tcs[0] = 1'b0;
    #1;
    n_cmp++;
    if (ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL umax_in_ready: got %b want 1", ir[0]);
    end
    @(posedge clk);  // accepting edge
    #1 iv[0] = 1'b0;
    for (int k = 1; k <= MPLIER_LAT; k++) begin
      #1;
      n_cmp++;
      if (ov[0] !== (k == MPLIER_LAT)) begin
        n_fail++; $display("FAIL umax_latency edge %0d: out_valid %b want %b", k, ov[0],
                           (k == MPLIER_LAT));
      end
      if (k == MPLIER_LAT) begin
        n_cmp++;
        if (pr[0] !== 64'hFE01) begin
          n_fail++; $display("FAIL umax_product: got %h want fe01", pr[0]);
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0]  a [5];
    logic [7:0]  b [5];
    logic        t [5];
    logic [63:0] e [5];
    int k;
    a = '{8'h80, 8'h80, 8'hFF, 8'h80, 8'hFF};
    b = '{8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F};
    t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    e = '{64'h4000, 64'h4000, 64'hFF81, 64'hC080, 64'h7E81};
    k = 0;
    drain();
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        iv[0] = 1'b1; mc[0] = 32'(a[c]); mp[0] = 32'(b[c]); tcs[0] = t[c];
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (ov[0]) begin
        n_cmp++;
        if (k >= 5) begin
          n_fail++; $display("FAIL mode_extra: unexpected product %h", pr[0]);
        end else if (pr[0] !== e[k]) begin
          n_fail++; $display("FAIL mode_product[%0d]: got %h want %h", k, pr[0], e[k]);
        end
        k++;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (k != 5) begin
      n_fail++; $display("FAIL mode_count: got %0d products want 5", k);
    end
  endtask

  task automatic test_backpressure();
    int sent, got, extra;
    logic [63:0] held;
    sent = 0; got = 0; extra = 0; held = '0;
    drain();
    for (int c = 0; c < 40 && got < 5; c++) begin
      ordy[0] = (c >= 6);
      if (sent < 5) begin
        iv[0] = 1'b1; mc[0] = 32'(sent + 1); mp[0] = 32'(sent + 1); tcs[0] = 1'b0;
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (c >= 3 && c < 6) begin
        n_cmp++;
        if (ir[0] !== 1'b0 || sent != 3) begin
          n_fail++; $display("FAIL bp_stall cycle %0d: in_ready %b held %0d want 0 and 3",
                             c, ir[0], sent);
        end
        if (c == 3) begin
          held = pr[0];
        end else begin
          n_cmp++;
          if (pr[0] !== held || ov[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold cycle %0d: product %h valid %b want %h 1",
                               c, pr[0], ov[0], held);
          end
        end
      end
      if (iv[0] && ir[0]) sent++;
      if (ov[0] && ordy[0]) begin
        n_cmp++;
        if (pr[0] !== 64'((got + 1) * (got + 1))) begin
          n_fail++; $display("FAIL bp_product[%0d]: got %h want %h", got, pr[0],
                             64'((got + 1) * (got + 1)));
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ov[0]) extra++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (got != 5 || sent != 5 || extra != 0) begin
      n_fail++; $display("FAIL bp_count: sent %0d got %0d extra %0d want 5 5 0",
                         sent, got, extra);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    drain();
    ordy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iv[0] = 1'b1; mc[0] = 32'(7 + 4 * c); mp[0] = 32'(9 + 2 * c); tcs[0] = c[0];
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (ov[0] !== 1'b0 || pr[0] !== 64'd0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state: valid %b product %h in_ready %b want 0 0 1",
                         ov[0], pr[0], ir[0]);
    end
    ordy[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (ov[0]) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midrst_leak: %0d stale products seen, want 0", seen);
    end
  endtask

  task automatic test_stress();
    int wr [3];
    int rd [3];
    int cyc;
    logic [31:0] msk;
    bit busy;
    drain();
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0; rd[i] = 0;
    end
    cyc = 0;
    busy = 1'b1;
    while (busy && cyc < MAX_CYC) begin
      for (int i = 0; i < 3; i++) begin
        msk = (32'd1 << wid[i]) - 32'd1;
        iv[i]   = (wr[i] < N_STRESS) && ($urandom_range(0, 3) != 0);
        mc[i]   = $urandom & msk;
        mp[i]   = $urandom & msk;
        tcs[i]  = $urandom_range(0, 1) == 1;
        ordy[i] = (wr[i] >= N_STRESS) || ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && ordy[i]) begin
          n_cmp++;
          if (rd[i] >= wr[i]) begin
            n_fail++; $display("FAIL stress_spurious w%0d: product %h with nothing pending",
                               wid[i], pr[i]);
          end else begin
            if (pr[i] !== exp_mem[i][rd[i]]) begin
              n_fail++; $display("FAIL stress_product w%0d #%0d: got %h want %h", wid[i],
                                 rd[i], pr[i], exp_mem[i][rd[i]]);
            end
            rd[i]++;
          end
        end
        if (iv[i] && ir[i]) begin
          exp_mem[i][wr[i]] = ref_mul(wid[i], mc[i], mp[i], tcs[i]);
          wr[i]++;
        end
      end
      busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (wr[i] < N_STRESS || rd[i] < wr[i]) busy = 1'b1;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wr[i] != N_STRESS || rd[i] != N_STRESS) begin
        n_fail++; $display("FAIL stress_done w%0d: accepted %0d emitted %0d want %0d in %0d cycles",
                           wid[i], wr[i], rd[i], N_STRESS, MAX_CYC);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wid = '{8, 16, 5};
    rst = 1'b1;
    idle_all();
    test_reset();
    test_unsigned_max();
    test_mode_switch();
    test_backpressure();
    test_reset_midflight();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
